// File: rtl/stream_host_bridge.sv
// ============================================================================
//  Module   : stream_host_bridge
//  Purpose  : Host-side TX/RX FIFO bridge for an accelerator AXI4-Stream pair.
//             Optional macro STREAM_HOST_COUNT_EN builds 32-bit transfer counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_host_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        host_flush,
  input  logic                        host_wr_valid,
  output logic                        host_wr_ready,
  input  logic [DATA_WIDTH-1:0]       host_wr_data,
  output logic                        host_rd_valid,
  input  logic                        host_rd_ready,
  output logic [DATA_WIDTH-1:0]       host_rd_data,
  output logic                        input_V_V_TVALID,
  input  logic                        input_V_V_TREADY,
  output logic [DATA_WIDTH-1:0]       input_V_V_TDATA,
  input  logic                        output_V_V_TVALID,
  output logic                        output_V_V_TREADY,
  input  logic [DATA_WIDTH-1:0]       output_V_V_TDATA,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [31:0]                 tx_count,
  output logic [31:0]                 rx_count
);

  localparam int c_TX_AW = $clog2(TX_DEPTH);
  localparam int c_RX_AW = $clog2(RX_DEPTH);
  localparam logic [c_TX_AW:0] c_TX_FULL = (c_TX_AW+1)'(TX_DEPTH);
  localparam logic [c_RX_AW:0] c_RX_FULL = (c_RX_AW+1)'(RX_DEPTH);

  logic [DATA_WIDTH-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];

  logic [c_TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [c_TX_AW:0]   tx_level_q, tx_level_d;
  logic [c_RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [c_RX_AW:0]   rx_level_q, rx_level_d;

  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;

  // Handshake qualifiers come only from registered levels, so no bypass paths exist.
  assign host_wr_ready     = (tx_level_q != c_TX_FULL);
  assign input_V_V_TVALID  = (tx_level_q != '0);
  assign input_V_V_TDATA   = input_V_V_TVALID ? tx_mem_q[tx_rptr_q] : '0;
  assign output_V_V_TREADY = (rx_level_q != c_RX_FULL);
  assign host_rd_valid     = (rx_level_q != '0);
  assign host_rd_data      = host_rd_valid ? rx_mem_q[rx_rptr_q] : '0;
  assign tx_level          = tx_level_q;
  assign rx_level          = rx_level_q;

  assign w_tx_push = host_wr_valid && host_wr_ready;
  assign w_tx_pop  = input_V_V_TVALID && input_V_V_TREADY;
  assign w_rx_push = output_V_V_TVALID && output_V_V_TREADY;
  assign w_rx_pop  = host_rd_valid && host_rd_ready;

  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_level_d = tx_level_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_level_d = rx_level_q;
    if (host_flush) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_level_d = '0;
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_level_d = '0;
    end else begin
      if (w_tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
      if (w_tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
      tx_level_d = tx_level_q + {{c_TX_AW{1'b0}}, w_tx_push}
                              - {{c_TX_AW{1'b0}}, w_tx_pop};
      if (w_rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
      if (w_rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
      rx_level_d = rx_level_q + {{c_RX_AW{1'b0}}, w_rx_push}
                              - {{c_RX_AW{1'b0}}, w_rx_pop};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_level_q <= '0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_level_q <= tx_level_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_level_q <= rx_level_d;
    end
  end

  // Storage needs no reset: stale words are masked by the level-derived valids.
  always_ff @(posedge aclk) begin
    if (w_tx_push && !host_flush) tx_mem_q[tx_wptr_q] <= host_wr_data;
    if (w_rx_push && !host_flush) rx_mem_q[rx_wptr_q] <= output_V_V_TDATA;
  end

`ifdef STREAM_HOST_COUNT_EN
  logic [31:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;

  always_comb begin
    tx_count_d = tx_count_q + {31'd0, w_tx_pop};
    rx_count_d = rx_count_q + {31'd0, w_rx_push};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
`else
  assign tx_count = '0;
  assign rx_count = '0;
`endif

endmodule

`default_nettype wire
